// File: rtl/gray_decoder.sv
// Tracks a Gray-coded counter: decodes it to binary, checks every sampled step,
// and records direction, forward wraps and illegal jumps.
module gray_decoder #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] Gray,
  input  logic             Resync,
  output logic [WIDTH-1:0] Binary,
  output logic             Valid,
  output logic             Up,
  output logic             Overflow,
  output logic             Error,
  output logic [7:0]       WrapCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Power-up values match the reset values so outputs are defined before the first Reset.
  state_t           state_q     = IDLE;
  logic [WIDTH-1:0] binary_q    = '0;
  logic             valid_q     = 1'b0;
  logic             up_q        = 1'b0;
  logic             overflow_q  = 1'b0;
  logic             error_q     = 1'b0;
  logic [7:0]       wrap_cnt_q  = 8'd0;

  logic [WIDTH-1:0] gray_bin;
  logic [WIDTH-1:0] step_d;
  logic [7:0]       wrap_cnt_d;

  always_comb begin
    gray_bin = '0;
    gray_bin[WIDTH-1] = Gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      gray_bin[i] = gray_bin[i+1] ^ Gray[i];
    end
  end

  // Modular distance from the tracked value to the new sample.
  assign step_d     = gray_bin - binary_q;
  assign wrap_cnt_d = (wrap_cnt_q == 8'hFF) ? wrap_cnt_q : wrap_cnt_q + 8'd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      binary_q   <= '0;
      valid_q    <= 1'b0;
      up_q       <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
      wrap_cnt_q <= 8'd0;
    end else if (Resync) begin
      // A simultaneous sample becomes the new reference immediately.
      if (En) begin
        binary_q <= gray_bin;
        valid_q  <= 1'b1;
        state_q  <= TRACK;
      end else begin
        valid_q  <= 1'b0;
        state_q  <= IDLE;
      end
    end else if (En) begin
      case (state_q)
        IDLE: begin
          binary_q <= gray_bin;
          valid_q  <= 1'b1;
          state_q  <= TRACK;
        end
        TRACK: begin
          if (step_d == '0) begin
            binary_q <= binary_q;
          end else if (step_d == WIDTH'(1)) begin
            binary_q <= gray_bin;
            up_q     <= 1'b1;
            if (binary_q == '1) begin
              overflow_q <= 1'b1;
              wrap_cnt_q <= wrap_cnt_d;
            end
          end else if (step_d == '1) begin
            binary_q <= gray_bin;
            up_q     <= 1'b0;
          end else begin
            error_q <= 1'b1;
            valid_q <= 1'b0;
            state_q <= FAULT;
          end
        end
        default: begin
          state_q <= FAULT;
        end
      endcase
    end
  end

  assign Binary    = binary_q;
  assign Valid     = valid_q;
  assign Up        = up_q;
  assign Overflow  = overflow_q;
  assign Error     = error_q;
  assign WrapCount = wrap_cnt_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Scoreboarded bench for gray_decoder: a reference model pushes expected outputs,
// a monitor pops and compares after each clock edge.
module tb_gray_decoder;

  localparam int W = 3;
  localparam int N = 1 << W;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         En = 1'b0;
  logic [W-1:0] Gray = '0;
  logic         Resync = 1'b0;
  logic [W-1:0] Binary;
  logic         Valid, Up, Overflow, Error;
  logic [7:0]   WrapCount;

  always #5 Clk = ~Clk;

  gray_decoder #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Gray(Gray), .Resync(Resync),
    .Binary(Binary), .Valid(Valid), .Up(Up), .Overflow(Overflow),
    .Error(Error), .WrapCount(WrapCount)
  );

  typedef struct packed {
    logic [W-1:0] bin;
    logic         valid;
    logic         up;
    logic         ovf;
    logic         err;
    logic [7:0]   wc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mon_a;
  int   tests = 0;
  int   fails = 0;
  int   txn   = 0;

  // Reference model state: plain integers and flags.
  int m_bin = 0;
  bit m_valid = 0, m_up = 0, m_ovf = 0, m_err = 0;
  int m_wc = 0;
  bit m_ref = 0, m_fault = 0;

  function automatic int dec(input int g);
    int b = 0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b % N;
  endfunction

  function automatic int enc(input int b);
    return (b ^ (b >> 1)) % N;
  endfunction

  task automatic step(input bit rst, input bit en, input bit rs, input int g);
    int v, d;
    exp_t e;
    @(negedge Clk);
    Reset = rst; En = en; Resync = rs; Gray = g[W-1:0];
    v = dec(g % N);
    if (rst) begin
      m_bin = 0; m_valid = 0; m_up = 0; m_ovf = 0; m_err = 0; m_wc = 0;
      m_ref = 0; m_fault = 0;
    end else if (rs) begin
      m_fault = 0;
      if (en) begin m_bin = v; m_valid = 1; m_ref = 1; end
      else begin m_valid = 0; m_ref = 0; end
    end else if (en && !m_fault) begin
      if (!m_ref) begin
        m_bin = v; m_valid = 1; m_ref = 1;
      end else begin
        d = (v - m_bin + N) % N;
        if (d == 1) begin
          if (m_bin == N - 1) begin
            m_ovf = 1;
            if (m_wc < 255) m_wc = m_wc + 1;
          end
          m_bin = v; m_up = 1;
        end else if (d == N - 1) begin
          m_bin = v; m_up = 0;
        end else if (d != 0) begin
          m_err = 1; m_valid = 0; m_fault = 1;
        end
      end
    end
    e.bin = m_bin[W-1:0]; e.valid = m_valid; e.up = m_up;
    e.ovf = m_ovf; e.err = m_err; e.wc = m_wc[7:0];
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {Binary, Valid, Up, Overflow, Error, WrapCount};
      tests++;
      txn++;
      if (mon_a !== mon_e) begin
        fails++;
        $display("[TB] FAIL txn%0d outputs: got bin=%0d valid=%b up=%b ovf=%b err=%b wc=%0d, want bin=%0d valid=%b up=%b ovf=%b err=%b wc=%0d",
                 txn, mon_a.bin, mon_a.valid, mon_a.up, mon_a.ovf, mon_a.err, mon_a.wc,
                 mon_e.bin, mon_e.valid, mon_e.up, mon_e.ovf, mon_e.err, mon_e.wc);
      end else begin
        $display("[TB] txn%0d ok bin=%0d valid=%b up=%b ovf=%b err=%b wc=%0d",
                 txn, mon_a.bin, mon_a.valid, mon_a.up, mon_a.ovf, mon_a.err, mon_a.wc);
      end
    end
  end

  initial begin
    int r, g;
    // Idle edge before any reset: power-up values must already be zero.
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    // One forward lap 0..7, wrap to 0, then a second full lap.
    for (int i = 0; i < N; i++) step(0, 1, 0, enc(i));
    step(0, 1, 0, enc(0));
    for (int i = 1; i <= N; i++) step(0, 1, 0, enc(i % N));
    // Climb to 3, then walk backward through 0 to 7.
    for (int i = 1; i <= 3; i++) step(0, 1, 0, enc(i));
    step(0, 1, 0, 3'b011); step(0, 1, 0, 3'b001);
    step(0, 1, 0, 3'b000); step(0, 1, 0, 3'b100);
    // En low holds, repeated code holds.
    step(0, 0, 0, 3'b010); step(0, 1, 0, 3'b100);
    // From 1, jump to 4 -> fault; further samples ignored.
    step(0, 1, 0, 3'b000); step(0, 1, 0, 3'b001);
    step(0, 1, 0, 3'b110); step(0, 1, 0, 3'b011); step(0, 1, 0, 3'b111);
    // Resync with sample in fault, then step down.
    step(0, 1, 1, 3'b101); step(0, 1, 0, 3'b111);
    // Resync alone, then reacquire at an arbitrary code.
    step(0, 0, 1, 3'b000); step(0, 1, 0, 3'b110);
    // Reset beats Resync and En; next sample is a fresh reference.
    step(1, 1, 1, 3'b110); step(0, 1, 0, 3'b010);
    // Saturate WrapCount with many forward laps.
    step(1, 0, 0, 0);
    for (int lap = 0; lap < 260; lap++)
      for (int i = 0; i < N; i++) step(0, 1, 0, enc(i));
    step(0, 1, 0, enc(0));
    // Randomized mix biased towards legal steps.
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      g = enc((m_bin + 1) % N);
      else if (r < 70) g = enc((m_bin + N - 1) % N);
      else if (r < 80) g = enc(m_bin);
      else             g = $urandom_range(0, N - 1);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 39) == 0, g);
    end
    @(negedge Clk);
    En = 0; Resync = 0; Reset = 0;
    repeat (3) @(negedge Clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
